// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, one-outstanding imem request channel, {pc, inst} FIFO, redirect and ebreak halt
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int          PW     = $clog2(DEPTH);
  localparam logic [PW:0] FULL   = (PW+1)'(DEPTH);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_e;

  state_e         state_q;
  logic [31:0]    fetch_pc_q;
  logic [31:0]    req_addr_q;
  logic           drop_q;
  logic [31:0]    pc_mem_q   [DEPTH];
  logic [31:0]    inst_mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW:0]    count_q;
  logic [PW:0]    count_d;

  logic [31:0] redir_tgt;
  logic        req_fire;
  logic        pop;
  logic        push;
  logic        unused_redirect_lsbs;

  assign redir_tgt            = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A request only goes out when a FIFO slot is free, so a response can always be pushed.
  assign imem_req_valid = !rst && (state_q == S_REQ) && (count_q < FULL);
  assign imem_req_addr  = req_addr_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (count_q != '0);
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst       = inst_mem_q[rd_ptr_q];
  assign halted     = (state_q == S_HALT);

  assign pop  = inst_valid && inst_ready;
  assign push = (state_q == S_WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;

  always_comb begin
    count_d = count_q;
    if (redirect_valid) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]   <= req_addr_q;
          inst_mem_q[wr_ptr_q] <= imem_rsp_data;
          wr_ptr_q             <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_q <= S_WAIT;
            if (redirect_valid) begin
              fetch_pc_q <= redir_tgt;
              drop_q     <= 1'b1;
            end
          end else if (redirect_valid) begin
            fetch_pc_q <= redir_tgt;
            // A visible but unaccepted request must stay stable; its response is dropped later.
            if (imem_req_valid) begin
              drop_q <= 1'b1;
            end else begin
              req_addr_q <= redir_tgt;
            end
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            fetch_pc_q <= redir_tgt;
            if (imem_rsp_valid) begin
              state_q    <= S_REQ;
              req_addr_q <= redir_tgt;
              drop_q     <= 1'b0;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q     <= 1'b0;
              state_q    <= S_REQ;
              req_addr_q <= fetch_pc_q;
            end else begin
              fetch_pc_q <= req_addr_q + 32'd4;
              req_addr_q <= req_addr_q + 32'd4;
              state_q    <= (imem_rsp_data == EBREAK) ? S_HALT : S_REQ;
            end
          end
        end
        S_HALT: begin
          if (redirect_valid) begin
            state_q    <= S_REQ;
            fetch_pc_q <= redir_tgt;
            req_addr_q <= redir_tgt;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch: vector table, directed redirect/ebreak cases, randomized run vs program-order model
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halted;

  ifu_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst(inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          drv_rst = 1'b1, drv_rdy = 1'b1, drv_irdy = 1'b1, drv_rv = 1'b0;
  logic [31:0] drv_rpc = '0;
  logic [31:0] ebreak_addr = 32'hFFFF_FFFF;
  int          lat_min = 1, lat_max = 1;

  bit          mem_pend = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_addr = '0;

  bit          o_req_valid, o_inst_valid, o_halted, o_rsp_valid;
  logic [31:0] o_req_addr, o_inst_pc, o_inst, o_rsp_data;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] req_log[$];
  logic [31:0] del_log[$];

  typedef struct {
    bit          rdy;
    bit          e_rv;
    logic [31:0] e_ra;
    bit          e_iv;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == ebreak_addr) ? EBRK : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] req_after(input logic [31:0] a);
    logic [31:0] r = 32'hDEAD_BEEF;
    for (int i = 0; i + 1 < req_log.size(); i++)
      if (req_log[i] == a) r = req_log[i+1];
    return r;
  endfunction

  function automatic int del_count(input logic [31:0] a);
    int n = 0;
    for (int i = 0; i < del_log.size(); i++)
      if (del_log[i] == a) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs and the memory model after the falling edge, then sample.
  task automatic tick();
    @(negedge clk);
    rst            = drv_rst;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (drv_rst) begin
      mem_pend = 1'b0;
    end else if (mem_pend) begin
      if (mem_delay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(mem_addr);
        mem_pend       = 1'b0;
      end else begin
        mem_delay--;
      end
    end
    imem_req_ready = drv_rdy;
    inst_ready     = drv_irdy;
    redirect_valid = drv_rv;
    redirect_pc    = drv_rpc;
    #1;
    o_req_valid  = imem_req_valid;
    o_req_addr   = imem_req_addr;
    o_inst_valid = inst_valid;
    o_inst_pc    = inst_pc;
    o_inst       = inst;
    o_halted     = halted;
    o_rsp_valid  = imem_rsp_valid;
    o_rsp_data   = imem_rsp_data;
    if (drv_rst) begin
      exp_pc = RST_PC;
    end else begin
      if (prev_stall) begin
        chk("req_hold_valid", 32'(o_req_valid), 32'd1);
        chk("req_hold_addr", o_req_addr, prev_addr);
      end
      if (o_req_valid && drv_rdy) begin
        chk("one_outstanding", 32'(mem_pend), 32'd0);
        chk("req_addr_align", 32'(o_req_addr[1:0]), 32'd0);
        mem_pend  = 1'b1;
        mem_addr  = o_req_addr;
        mem_delay = int'($urandom_range(lat_max, lat_min)) - 1;
        req_log.push_back(o_req_addr);
      end
      if (o_inst_valid && drv_irdy) begin
        chk("inst_pc_order", o_inst_pc, exp_pc);
        chk("inst_word", o_inst, word(exp_pc));
        del_log.push_back(o_inst_pc);
        exp_pc += 32'd4;
      end
      if (drv_rv) exp_pc = {drv_rpc[31:2], 2'b00};
    end
    prev_stall = !drv_rst && o_req_valid && !drv_rdy;
    prev_addr  = o_req_addr;
  endtask

  task automatic do_reset();
    drv_rst = 1'b1; drv_rv = 1'b0; drv_rdy = 1'b1; drv_irdy = 1'b1;
    tick();
    tick();
    chk("rst_req_valid", 32'(o_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(o_inst_valid), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    drv_rst = 1'b0;
    req_log.delete();
    del_log.delete();
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (req_log.size() > 0 && req_log[req_log.size()-1] == a) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    bit saw_prev, eb_seen;

    tbl[0]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0008};
    tbl[7]  = '{1'b0, 1'b1, 32'h8000_000C, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 32'h8000_000C, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 32'h8000_000C, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_000C};

    // Sequential fetch with a 3-cycle request stall, 1-cycle memory.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drv_rdy = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_req_valid", i), 32'(o_req_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("vec%0d_req_addr", i), o_req_addr, tbl[i].e_ra);
      chk($sformatf("vec%0d_inst_valid", i), 32'(o_inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) chk($sformatf("vec%0d_inst_pc", i), o_inst_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_halted", i), 32'(o_halted), 32'd0);
    end

    // Backpressure: exactly DEPTH words fetched, then resume in order.
    do_reset();
    drv_irdy = 1'b0;
    repeat (9) tick();
    chk("bp_req_count", req_log.size(), 32'd2);
    chk("bp_req_valid_low", 32'(o_req_valid), 32'd0);
    chk("bp_head_pc", o_inst_pc, 32'h8000_0000);
    drv_irdy = 1'b1;
    repeat (6) tick();
    chk("bp_del0", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h8000_0000);
    chk("bp_del1", (del_log.size() > 1) ? del_log[1] : 32'hDEAD_BEEF, 32'h8000_0004);
    chk("bp_resume", (req_log.size() > 2) ? req_log[2] : 32'hDEAD_BEEF, 32'h8000_0008);

    // Redirect in WAIT, response arrives later.
    do_reset();
    lat_min = 3; lat_max = 3;
    wait_req(32'h8000_0010, "wa_setup");
    drv_rv = 1'b1; drv_rpc = 32'h8000_0103;
    tick();
    chk("wa_no_rsp", 32'(o_rsp_valid), 32'd0);
    drv_rv = 1'b0;
    repeat (14) tick();
    chk("wa_next_req", req_after(32'h8000_0010), 32'h8000_0100);
    chk("wa_dropped", del_count(32'h8000_0010), 32'd0);
    chk("wa_target_del", del_count(32'h8000_0100), 32'd1);

    // Redirect in WAIT, coincident with the response.
    do_reset();
    wait_req(32'h8000_0010, "wb_setup");
    for (int i = 0; i < 10 && !(mem_pend && mem_delay == 0); i++) tick();
    drv_rv = 1'b1; drv_rpc = 32'h8000_0103;
    tick();
    chk("wb_coincident", 32'(o_rsp_valid), 32'd1);
    drv_rv = 1'b0;
    repeat (12) tick();
    chk("wb_next_req", req_after(32'h8000_0010), 32'h8000_0100);
    chk("wb_dropped", del_count(32'h8000_0010), 32'd0);
    lat_min = 1; lat_max = 1;

    // Redirect with two queued entries and a head handshake in the same cycle.
    do_reset();
    drv_irdy = 1'b0;
    repeat (6) tick();
    chk("rq_full", 32'(o_inst_valid), 32'd1);
    drv_irdy = 1'b1; drv_rv = 1'b1; drv_rpc = 32'h8000_0300;
    tick();
    drv_rv = 1'b0;
    tick();
    chk("rq_flushed", 32'(o_inst_valid), 32'd0);
    chk("rq_req_valid", 32'(o_req_valid), 32'd1);
    chk("rq_req_addr", o_req_addr, 32'h8000_0300);
    repeat (6) tick();
    chk("rq_del0", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h8000_0000);
    chk("rq_del1", (del_log.size() > 1) ? del_log[1] : 32'hDEAD_BEEF, 32'h8000_0300);
    chk("rq_second_gone", del_count(32'h8000_0004), 32'd0);

    // ebreak halts fetch; a redirect restarts it.
    ebreak_addr = 32'h8000_000C;
    do_reset();
    saw_prev = 1'b0; eb_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (saw_prev) begin
        chk("eb_halted_rise", 32'(o_halted), 32'd1);
        saw_prev = 1'b0;
      end
      if (o_rsp_valid && o_rsp_data == EBRK) begin
        saw_prev = 1'b1;
        eb_seen  = 1'b1;
      end
    end
    chk("eb_seen", 32'(eb_seen), 32'd1);
    chk("eb_halted", 32'(o_halted), 32'd1);
    chk("eb_req_count", req_log.size(), 32'd4);
    chk("eb_delivered", del_count(32'h8000_000C), 32'd1);
    drv_rv = 1'b1; drv_rpc = 32'h8000_0200;
    tick();
    chk("eb_halted_at_redirect", 32'(o_halted), 32'd1);
    drv_rv = 1'b0;
    tick();
    chk("eb_halted_fall", 32'(o_halted), 32'd0);
    chk("eb_restart_valid", 32'(o_req_valid), 32'd1);
    chk("eb_restart_addr", o_req_addr, 32'h8000_0200);
    repeat (4) tick();
    chk("eb_restart_del", del_count(32'h8000_0200), 32'd1);
    ebreak_addr = 32'hFFFF_FFFF;

    // Randomized traffic against the program-order model.
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      drv_rdy  = ($urandom_range(0, 3) != 0);
      drv_irdy = ($urandom_range(0, 3) != 0);
      drv_rv   = ($urandom_range(0, 19) == 0);
      drv_rpc  = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      tick();
      chk("rnd_halted", 32'(o_halted), 32'd0);
    end
    chk("rnd_progress", 32'(del_log.size() > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
